// File: rtl/div.sv
// div: multi-cycle radix-2 restoring 32-bit divider (MIPS DIV), quotient in lo, remainder in hi.
// Optional macro DIV_UNSIGNED_EN adds the div_unsigned input for DIVU semantics.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
`ifdef DIV_UNSIGNED_EN
    input  logic        div_unsigned,
`endif
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_end,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [31:0] mb_q, mb_d, q_q, q_d, r_q, r_d, hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  n_q, n_d;
    logic        end_q, end_d, zero_q, zero_d, busy_q, busy_d;
    logic        us;
    logic [31:0] ma, mbv;
    logic [32:0] rs;
    logic [33:0] t;

`ifdef DIV_UNSIGNED_EN
    assign us = div_unsigned;
`else
    assign us = 1'b0;
`endif

    // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign ma  = (!us && A[31]) ? -A : A;
    assign mbv = (!us && B[31]) ? -B : B;
    // Remainder never exceeds |B|-1, so 32 bits hold it; the shifted-in value needs 33.
    assign rs  = {r_q, q_q[31]};
    assign t   = {1'b0, rs} - {2'b00, mb_q};

    // State register, updated on the falling edge.
    always_ff @(negedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    // Next-state logic: zero divisor skips the iteration phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_start) state_d = (B == 32'd0) ? FIX : CALC;
            CALC:    if (n_q == 5'd31) state_d = FIX;
            default: state_d = IDLE;
        endcase
    end

    // Datapath/output next values; Q starts as |A| so the zero-divisor path can rebuild A from it.
    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        mb_d   = mb_q;
        q_d    = q_q;
        r_d    = r_q;
        n_d    = n_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        zero_d = zero_q;
        busy_d = busy_q;
        end_d  = 1'b0;
        case (state_q)
            IDLE: if (div_start) begin
                sa_d   = !us && A[31];
                sb_d   = !us && B[31];
                mb_d   = mbv;
                q_d    = ma;
                r_d    = 32'd0;
                n_d    = 5'd0;
                zero_d = (B == 32'd0);
                busy_d = 1'b1;
            end
            CALC: begin
                r_d = t[33] ? rs[31:0] : t[31:0];
                q_d = {q_q[30:0], ~t[33]};
                n_d = n_q + 5'd1;
            end
            default: begin
                lo_d   = zero_q ? 32'hFFFF_FFFF : ((sa_q ^ sb_q) ? -q_q : q_q);
                hi_d   = zero_q ? (sa_q ? -q_q : q_q) : (sa_q ? -r_q : r_q);
                end_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath registers with asynchronous clear.
    always_ff @(negedge clk or posedge rst)
        if (rst) begin
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            mb_q   <= 32'd0;
            q_q    <= 32'd0;
            r_q    <= 32'd0;
            n_q    <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            end_q  <= 1'b0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            mb_q   <= mb_d;
            q_q    <= q_d;
            r_q    <= r_d;
            n_q    <= n_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            end_q  <= end_d;
            zero_q <= zero_d;
            busy_q <= busy_d;
        end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_end  = end_q;
    assign div_zero = zero_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed and random checks of div against an arithmetic reference model.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start = 1'b0;
    logic        du = 1'b0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic [31:0] hi, lo;
    logic        div_end, div_zero, busy;
    int          tests = 0, fails = 0;

    div dut (
        .clk(clk), .rst(rst), .div_start(div_start),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned(du),
`endif
        .A(A), .B(B), .hi(hi), .lo(lo),
        .div_end(div_end), .div_zero(div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic; truncating division, remainder follows dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         output logic [31:0] eq, output logic [31:0] er);
        longint x, y, qq, rr;
        x = uns ? longint'({32'd0, a}) : longint'($signed(a));
        y = uns ? longint'({32'd0, b}) : longint'($signed(b));
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else begin
            qq = x / y;
            rr = x % y;
            eq = qq[31:0];
            er = rr[31:0];
        end
    endtask

    // Issue one operation from a rising edge; hold keeps start high for a back-to-back follow-up.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic uns, input logic hold);
        logic [31:0] eq, er;
        int k;
        model(a, b, uns, eq, er);
        A = a; B = b; du = uns; div_start = 1'b1;
        @(negedge clk);
        for (k = 0; k < 40; k++) begin
            @(posedge clk);
            if (k == 0) begin
                chk({tag, ".end_low_at_accept"}, {31'd0, div_end}, 32'd0);
                A = $urandom; B = $urandom; du = ~uns;
                if (!hold) div_start = 1'b0;
            end
            if (div_end) break;
            if (busy !== 1'b1) chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        end
        chk({tag, ".latency"}, k, (b == 32'd0) ? 1 : 33);
        chk({tag, ".lo"}, lo, eq);
        chk({tag, ".hi"}, hi, er);
        chk({tag, ".zero"}, {31'd0, div_zero}, {31'd0, b == 32'd0});
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".hi"}, hi, 32'd0);
        chk({tag, ".lo"}, lo, 32'd0);
        chk({tag, ".end"}, {31'd0, div_end}, 32'd0);
        chk({tag, ".zero"}, {31'd0, div_zero}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, lo_s, hi_s;
        logic seen;
        #2;
        chk_reset("reset");
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        op("7/2", 32'd7, 32'd2, 1'b0, 1'b0);
        op("-7/2", -32'sd7, 32'd2, 1'b0, 1'b0);
        op("7/-2", 32'd7, -32'sd2, 1'b0, 1'b0);
        op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op("dz", 32'h1234, 32'd0, 1'b0, 1'b0);
        op("dz_neg", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        op("b2b", 32'd1000, -32'sd7, 1'b0, 1'b0);
        lo_s = lo; hi_s = hi;
        @(posedge clk);
        chk("pulse_once", {31'd0, div_end}, 32'd0);
        repeat (3) @(posedge clk);
        chk("hold_lo", lo, lo_s);
        chk("hold_hi", hi, hi_s);
        A = 32'd100; B = 32'd3; div_start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk_reset("abort");
        @(posedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            seen = seen | div_end;
        end
        chk("abort_no_end", {31'd0, seen}, 32'd0);
        op("100/3", 32'd100, 32'd3, 1'b0, 1'b0);
`ifdef DIV_UNSIGNED_EN
        op("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        op("divu_dz", 32'h8765_4321, 32'd0, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 6 == 0) ? 32'd0 : (i % 3 == 0) ? $urandom_range(1, 9) : $urandom;
            if (i % 4 == 1) b = -b;
`ifdef DIV_UNSIGNED_EN
            op("rand", a, b, i[0], i % 5 == 0);
`else
            op("rand", a, b, 1'b0, i % 5 == 0);
`endif
        end
        @(posedge clk);
        div_start = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
